// File: rtl/apb_master_if.sv
// APB requester bundle: command stream, response channel and APB bus signals.
// The master modport is the requester's view; slave is the opposite side.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns read data / error on a held response channel.
// Optional access-phase timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  cmd_ready_c;
    logic                  accept;
    logic                  complete;
    logic                  psel_c;
    logic                  penable_c;

    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    assign accept = bus.cmd_valid && cmd_ready_c;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             expire;

    // Terminates on the last of TIMEOUT_CYCLES stalled ACCESS cycles; PREADY wins.
    assign expire = (state == ACCESS) && !bus.PREADY &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stalled ACCESS-cycle counter, restarted for every accepted command.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, bus phase strobes and command acceptance.
    always_comb begin
        state_nxt   = state;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        cmd_ready_c = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by PRESET so every output reads 0 while reset is held.
                cmd_ready_c = !PRESET && (!rsp_valid_q || bus.rsp_ready);
                if (bus.cmd_valid && cmd_ready_c) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel_c    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (bus.PREADY) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (expire) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address/data phase registers, loaded on accept and held otherwise.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
        end
    end

    // Response capture; a completion on the consuming edge overwrites the old one.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (complete) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q   <= bus.PSLVERR;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (expire) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
        end
`endif
        else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL      = psel_c;
    assign bus.PENABLE   = penable_c;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: table of transfers plus hand-written sequences
// for backpressure, mid-transfer reset and the access-phase timeout.
module tb_apb_master;

    logic PCLK;
    logic PRESET;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus_if ();

    apb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus_if.master)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } slv_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    slv_t        slave_q[$];
    logic [32:0] exp_q[$];
    vec_t        vecs[10];

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        forever begin
            @(posedge PCLK);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic bus_chk(input string name, input vec_t v);
        chk(name, {bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA, bus_if.PSTRB},
            {v.write, v.addr, (v.write ? v.wdata : 32'h0), (v.write ? v.strb : 4'h0)});
    endtask

    task automatic zero_chk(input string name);
        chk(name, {bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA,
                   bus_if.PSTRB, bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rdata,
                   bus_if.rsp_err}, '0);
    endtask

    // Completer model: follows the per-transfer wait/data script, random junk elsewhere.
    initial begin
        int k;
        k = 0;
        bus_if.PREADY  = 1'b0;
        bus_if.PRDATA  = '0;
        bus_if.PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if (bus_if.PSEL && bus_if.PENABLE && slave_q.size() > 0) begin
                if (k >= slave_q[0].waits) begin
                    bus_if.PREADY  = 1'b1;
                    bus_if.PRDATA  = slave_q[0].prdata;
                    bus_if.PSLVERR = slave_q[0].slverr;
                    void'(slave_q.pop_front());
                    k = 0;
                end else begin
                    bus_if.PREADY  = 1'b0;
                    bus_if.PRDATA  = $urandom;
                    bus_if.PSLVERR = 1'($urandom_range(0, 1));
                    k++;
                end
            end else begin
                bus_if.PREADY  = 1'($urandom_range(0, 1));
                bus_if.PRDATA  = $urandom;
                bus_if.PSLVERR = 1'($urandom_range(0, 1));
                k = 0;
            end
        end
    end

    // Scoreboard: compare each consumed response against the oldest expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge PCLK);
            if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data_err", {bus_if.rsp_rdata, bus_if.rsp_err}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        checks++;
        $display("FAIL watchdog actual=running required=finished");
        finish_run();
    end

    // Presents a command and returns one time unit after the accepting edge.
    task automatic start_cmd(input vec_t v, output int rdy_wait, output int acc_cyc);
        slave_q.push_back('{waits: v.waits, prdata: v.prdata, slverr: v.slverr});
        bus_if.cmd_write = v.write;
        bus_if.cmd_addr  = v.addr;
        bus_if.cmd_wdata = v.wdata;
        bus_if.cmd_strb  = v.strb;
        bus_if.cmd_valid = 1'b1;
        rdy_wait = 0;
        forever begin
            @(negedge PCLK);
            if (bus_if.cmd_ready) break;
            rdy_wait++;
            if (rdy_wait > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_bound actual=not_accepted required=accepted");
                finish_run();
            end
        end
        @(posedge PCLK);
        #1;
        acc_cyc = cyc;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'($urandom_range(0, 1));
        bus_if.cmd_addr  = $urandom;
        bus_if.cmd_wdata = $urandom;
        bus_if.cmd_strb  = 4'($urandom);
    endtask

    // Full transfer: phase/timing checks, returns one time unit after completion.
    task automatic issue(input vec_t v, input int exp_access, output int rdy_wait, output int acc_cyc);
        int n;
        bit fin;
        start_cmd(v, rdy_wait, acc_cyc);
        exp_q.push_back({v.exp_rdata, v.exp_err});
        chk("setup_phase", {bus_if.PSEL, bus_if.PENABLE, bus_if.rsp_valid}, 3'b100);
        bus_chk("setup_bus", v);
        @(posedge PCLK);
        #1;
        chk("access_phase", {bus_if.PSEL, bus_if.PENABLE}, 2'b11);
        bus_chk("access_bus", v);
        n = 1;
        fin = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge PCLK);
            #1;
            if (!bus_if.PSEL) begin
                fin = 1;
                break;
            end
            n++;
            chk("access_hold", {bus_if.PSEL, bus_if.PENABLE}, 2'b11);
            bus_chk("access_bus_hold", v);
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL completion_bound actual=no_completion required=completion");
            finish_run();
        end
        chk("access_cycles", n, exp_access);
        chk("rsp_valid_done", {bus_if.rsp_valid, bus_if.PENABLE}, 2'b10);
    endtask

    task automatic abort_reset();
        #2;
        PRESET = 1'b1;
        #1;
        zero_chk("reset_async_zero");
        @(posedge PCLK);
        #1;
        slave_q.delete();
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK);
            #1;
            chk("no_rsp_after_reset", {bus_if.rsp_valid, bus_if.PSEL}, 2'b00);
        end
    endtask

    initial begin
        int   rw;
        int   ac;
        int   prev_ac;
        vec_t v;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0024, 32'h1111_2222, 4'hF, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0204, 32'h0BAD_F00D, 4'h3, 1, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0208, 32'h8765_4321, 4'h9, 2, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 5, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 32'hA5A5_0002, 1'b0, 32'hA5A5_0002, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_1008, 32'h0000_0003, 4'h1, 0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[9] = '{1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 32'h5A5A_0004, 1'b0, 32'h5A5A_0004, 1'b0};

        PRESET           = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.cmd_strb  = '0;
        bus_if.rsp_ready = 1'b1;
        #1;
        PRESET           = 1'b1;
        bus_if.cmd_valid = 1'b1;
        #1;
        zero_chk("reset_outputs");
        bus_if.cmd_valid = 1'b0;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Table: single transfers with various waits, then four back-to-back.
        prev_ac = 0;
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i], vecs[i].waits + 1, rw, ac);
            chk("accept_wait", rw, 0);
            if (i > 0) chk("transfer_spacing", ac - prev_ac, 3 + vecs[i-1].waits);
            prev_ac = ac;
        end

        // Error response held under backpressure, next command waits for consumption.
        @(posedge PCLK);
        #1;
        bus_if.rsp_ready = 1'b0;
        v = '{1'b1, 32'h0000_0300, 32'h55AA_55AA, 4'hF, 0, 32'h1357_9BDF, 1'b1, 32'h0, 1'b1};
        issue(v, 1, rw, ac);
        v = '{1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0};
        bus_if.cmd_write = v.write;
        bus_if.cmd_addr  = v.addr;
        bus_if.cmd_wdata = v.wdata;
        bus_if.cmd_strb  = v.strb;
        bus_if.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("bp_rsp_hold", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, {2'b11, 32'h0});
            chk("bp_no_accept", {bus_if.cmd_ready, bus_if.PSEL}, 2'b00);
        end
        @(posedge PCLK);
        #1;
        bus_if.rsp_ready = 1'b1;
        issue(v, 1, rw, ac);
        chk("bp_accept_on_release", rw, 0);

        // Reset during a stalled ACCESS phase, then a normal transfer.
        v = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b0};
        start_cmd(v, rw, ac);
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        chk("pre_reset_access", {bus_if.PSEL, bus_if.PENABLE}, 2'b11);
        abort_reset();
        v = '{1'b0, 32'h0000_0028, 32'h0, 4'h0, 0, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 1'b0};
        issue(v, 1, rw, ac);
        chk("post_reset_accept", rw, 0);

        // Completer that never answers.
        v = '{1'b0, 32'h0000_0500, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b1};
`ifdef APB_MASTER_TIMEOUT_EN
        issue(v, 16, rw, ac);
        slave_q.delete();
`else
        start_cmd(v, rw, ac);
        repeat (100) begin
            @(posedge PCLK);
            #1;
        end
        chk("no_timeout_still_access", {bus_if.PSEL, bus_if.PENABLE, bus_if.rsp_valid}, 3'b110);
        abort_reset();
`endif
        v = '{1'b1, 32'h0000_0600, 32'hFEED_FACE, 4'hC, 2, 32'h0, 1'b0, 32'h0, 1'b0};
        issue(v, 3, rw, ac);

        repeat (3) begin
            @(posedge PCLK);
            #1;
        end
        chk("rsp_all_consumed", exp_q.size(), 0);
        finish_run();
    end

endmodule
